pixie_dp_front_end: RTL and testbench

PIXIE_DP_FRONT_END -- requirements
Module: pixie_dp_front_end

---
 rtl/pixie_dp_front_end_if.sv | 26 ++
 rtl/pixie_dp_front_end.sv | 117 +++++++++++
 tb/tb_pixie_dp_front_end.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pixie_dp_front_end_if.sv
// Bus bundle between the CDP1802-style CPU and the Pixie display front end.
// The front end takes the slave view; the CPU/bench side takes the master view.
interface pixie_dp_front_end_if;
   logic       clk_enable;
   logic       disp_on;
   logic       disp_off;
   logic [1:0] sc;
   logic [7:0] data_in;
   logic       int_n;
   logic       efx_n;
   logic       dmao_n;
   logic       fb_write_en;
   logic [9:0] fb_addr;
   logic [7:0] fb_data;
   logic       display_enabled;

   modport slave (
      input  clk_enable, disp_on, disp_off, sc, data_in,
      output int_n, efx_n, dmao_n, fb_write_en, fb_addr, fb_data, display_enabled
   );

   modport master (
      output clk_enable, disp_on, disp_off, sc, data_in,
      input  int_n, efx_n, dmao_n, fb_write_en, fb_addr, fb_data, display_enabled
   );
endinterface

// File: rtl/pixie_dp_front_end.sv
// Pixie-style display front end: beam timing, EF/INT generation and DMA-out
// byte capture into a frame buffer write port.
module pixie_dp_front_end #(
   parameter int cycles_per_line = 14,
   parameter int lines_per_frame = 262,
   parameter int first_dma_line  = 64,
   parameter int dma_lines       = 128,
   parameter int int_line        = 62,
   parameter int bytes_per_line  = 8
) (
   input  logic                   clk,
   input  logic                   reset_n,
   pixie_dp_front_end_if.slave    bus
);

   localparam int CYW = $clog2(cycles_per_line);
   localparam int LW  = $clog2(lines_per_frame);
   localparam int CW  = $clog2(bytes_per_line + 1);

   localparam logic [CYW-1:0] CYC_LAST  = CYW'(cycles_per_line - 1);
   localparam logic [CYW-1:0] CYC_DMA   = CYW'(2);
   localparam logic [LW-1:0]  LINE_LAST = LW'(lines_per_frame - 1);
   localparam logic [LW-1:0]  EFX_A_LO  = LW'(int_line - 2);
   localparam logic [LW-1:0]  INT_LO    = LW'(int_line);
   localparam logic [LW-1:0]  INT_HI    = LW'(int_line + 1);
   localparam logic [LW-1:0]  DMA_LO    = LW'(first_dma_line);
   localparam logic [LW-1:0]  DMA_HI    = LW'(first_dma_line + dma_lines - 1);
   localparam logic [LW-1:0]  EFX_B_LO  = LW'(first_dma_line + dma_lines - 4);
   localparam logic [CW-1:0]  COL_FULL  = CW'(bytes_per_line);

   logic [CYW-1:0] cycle_q, cycle_d;
   logic [LW-1:0]  line_q, line_d;
   logic [CW-1:0]  col_q, col_d;
   logic           disp_q, disp_d;
   logic           wr_q, wr_d;
   logic [9:0]     addr_q, addr_d;
   logic [7:0]     data_q, data_d;

   logic           line_end;
   logic           dma_req;
   logic           accept;
   logic [6:0]     row;

   assign row = 7'(line_q - DMA_LO);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cycle_q <= '0;
         line_q  <= '0;
         col_q   <= '0;
         disp_q  <= 1'b0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         cycle_q <= cycle_d;
         line_q  <= line_d;
         col_q   <= col_d;
         disp_q  <= disp_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

   always_comb begin
      cycle_d  = cycle_q;
      line_d   = line_q;
      col_d    = col_q;
      disp_d   = disp_q;
      addr_d   = addr_q;
      data_d   = data_q;
      line_end = bus.clk_enable && (cycle_q == CYC_LAST);

      // col_q counts bytes taken this line, so it also ends the request
      dma_req  = disp_q && (line_q >= DMA_LO) && (line_q <= DMA_HI) &&
                 (cycle_q >= CYC_DMA) && (col_q < COL_FULL);
      accept   = bus.clk_enable && (bus.sc == 2'b10) && dma_req;
      wr_d     = accept;

      if (bus.clk_enable) begin
         if (cycle_q == CYC_LAST) begin
            cycle_d = '0;
            line_d  = (line_q == LINE_LAST) ? '0 : line_q + 1'b1;
         end else begin
            cycle_d = cycle_q + 1'b1;
         end
      end

      if (accept) begin
         addr_d = {row, col_q[2:0]};
         data_d = bus.data_in;
      end

      if (line_end) begin
         col_d = '0;
      end else if (accept) begin
         col_d = col_q + 1'b1;
      end

      if (bus.disp_off) begin
         disp_d = 1'b0;
      end else if (bus.disp_on) begin
         disp_d = 1'b1;
      end
   end

   assign bus.efx_n = !(((line_q >= EFX_A_LO) && (line_q <= INT_HI)) ||
                        ((line_q >= EFX_B_LO) && (line_q <= DMA_HI)));
   assign bus.int_n           = !(disp_q && (line_q >= INT_LO) && (line_q <= INT_HI));
   assign bus.dmao_n          = !dma_req;
   assign bus.fb_write_en     = wr_q;
   assign bus.fb_addr         = addr_q;
   assign bus.fb_data         = data_q;
   assign bus.display_enabled = disp_q;

endmodule

// File: tb/tb_pixie_dp_front_end.sv
// Bench for pixie_dp_front_end: frame-position reference model checked every
// clock, a vector table of beam positions, and directed DMA corner sequences.
module tb_pixie_dp_front_end;

   localparam int CPL   = 14;
   localparam int LPF   = 262;
   localparam int FRAME = CPL * LPF;

   logic clk;
   logic reset_n;
   pixie_dp_front_end_if bus ();

   pixie_dp_front_end dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   bit chk_on = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         if (n_err <= 40)
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: beam position as a single count of machine cycles.
   int       m_pos;
   bit       m_disp;
   int       m_taken;
   bit       m_wr;
   int       m_addr;
   int       m_data;

   function automatic bit e_efx_n();
      int ln = m_pos / CPL;
      return !((ln >= 60 && ln <= 63) || (ln >= 188 && ln <= 191));
   endfunction

   function automatic bit e_int_n();
      int ln = m_pos / CPL;
      return !(m_disp && ln >= 62 && ln <= 63);
   endfunction

   function automatic bit e_dmao_n();
      int ln = m_pos / CPL;
      int cy = m_pos % CPL;
      return !(m_disp && ln >= 64 && ln <= 191 && cy >= 2 && m_taken < 8);
   endfunction

   always @(posedge clk) begin
      if (!reset_n) begin
         m_pos   <= 0;
         m_disp  <= 0;
         m_taken <= 0;
         m_wr    <= 0;
         m_addr  <= 0;
         m_data  <= 0;
      end else begin
         m_wr <= bus.clk_enable && bus.sc == 2'b10 && !e_dmao_n();
         if (bus.clk_enable && bus.sc == 2'b10 && !e_dmao_n()) begin
            m_addr  <= (m_pos / CPL - 64) * 8 + m_taken;
            m_data  <= int'(bus.data_in);
            m_taken <= m_taken + 1;
         end
         if (bus.disp_off)     m_disp <= 0;
         else if (bus.disp_on) m_disp <= 1;
         if (bus.clk_enable) begin
            m_pos <= (m_pos + 1) % FRAME;
            if ((m_pos + 1) % CPL == 0) m_taken <= 0;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         chk("bg_display_enabled", 32'(bus.display_enabled), 32'(m_disp));
         chk("bg_efx_n",           32'(bus.efx_n),           32'(e_efx_n()));
         chk("bg_int_n",           32'(bus.int_n),           32'(e_int_n()));
         chk("bg_dmao_n",          32'(bus.dmao_n),          32'(e_dmao_n()));
         chk("bg_fb_write_en",     32'(bus.fb_write_en),     32'(m_wr));
         chk("bg_fb_addr",         32'(bus.fb_addr),         32'(m_addr));
         chk("bg_fb_data",         32'(bus.fb_data),         32'(m_data));
      end
   end

   task automatic step(input logic ce, input logic [1:0] s, input logic [7:0] d,
                       input logic on, input logic off, input logic rn);
      bus.clk_enable = ce;
      bus.sc         = s;
      bus.data_in    = d;
      bus.disp_on    = on;
      bus.disp_off   = off;
      reset_n        = rn;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle();
      step(1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic adv_to(input int ln, input int cy);
      int tgt = ln * CPL + cy;
      int guard = 0;
      while (m_pos != tgt && guard < 2 * FRAME) begin
         step(1'b1, 2'b00, 8'h00, 1'b0, 1'b0, 1'b1);
         guard++;
      end
      if (m_pos != tgt) begin
         n_err++;
         $display("FAIL advance: position %0d never reached target %0d", m_pos, tgt);
      end
   endtask

   typedef struct {
      int   ln;
      int   cy;
      int   cmd;   // 0 none, 1 disp_on, 2 disp_off, 3 both
      logic efx_n;
      logic int_n;
      logic dmao_n;
      logic de;
   } vec_t;

   vec_t tbl[17];

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      int efx_low, int_low, dma_low, wr_cnt;

      tbl[0]  = '{0,   0,  0, 1'b1, 1'b1, 1'b1, 1'b0};
      tbl[1]  = '{59,  13, 1, 1'b1, 1'b1, 1'b1, 1'b1};
      tbl[2]  = '{60,  0,  0, 1'b0, 1'b1, 1'b1, 1'b1};
      tbl[3]  = '{62,  0,  2, 1'b0, 1'b1, 1'b1, 1'b0};
      tbl[4]  = '{62,  5,  1, 1'b0, 1'b0, 1'b1, 1'b1};
      tbl[5]  = '{62,  6,  3, 1'b0, 1'b1, 1'b1, 1'b0};
      tbl[6]  = '{63,  13, 1, 1'b0, 1'b0, 1'b1, 1'b1};
      tbl[7]  = '{64,  1,  0, 1'b1, 1'b1, 1'b1, 1'b1};
      tbl[8]  = '{64,  2,  0, 1'b1, 1'b1, 1'b0, 1'b1};
      tbl[9]  = '{64,  3,  2, 1'b1, 1'b1, 1'b1, 1'b0};
      tbl[10] = '{65,  2,  1, 1'b1, 1'b1, 1'b0, 1'b1};
      tbl[11] = '{187, 13, 0, 1'b1, 1'b1, 1'b0, 1'b1};
      tbl[12] = '{188, 3,  0, 1'b0, 1'b1, 1'b0, 1'b1};
      tbl[13] = '{191, 13, 0, 1'b0, 1'b1, 1'b0, 1'b1};
      tbl[14] = '{192, 2,  0, 1'b1, 1'b1, 1'b1, 1'b1};
      tbl[15] = '{261, 13, 0, 1'b1, 1'b1, 1'b1, 1'b1};
      tbl[16] = '{0,   2,  0, 1'b1, 1'b1, 1'b1, 1'b1};

      step(1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0);
      step(1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0);
      chk_on = 1;
      chk("reset_int_n",  32'(bus.int_n), 1);
      chk("reset_efx_n",  32'(bus.efx_n), 1);
      chk("reset_dmao_n", 32'(bus.dmao_n), 1);
      chk("reset_fb_write_en", 32'(bus.fb_write_en), 0);
      chk("reset_fb_addr", 32'(bus.fb_addr), 0);
      chk("reset_fb_data", 32'(bus.fb_data), 0);
      chk("reset_display_enabled", 32'(bus.display_enabled), 0);

      // Beam-position vector table
      for (int i = 0; i < 17; i++) begin
         adv_to(tbl[i].ln, tbl[i].cy);
         step(1'b0, 2'b00, 8'h00, tbl[i].cmd[0], tbl[i].cmd[1], 1'b1);
         chk($sformatf("tbl%0d_efx_n", i),  32'(bus.efx_n),  32'(tbl[i].efx_n));
         chk($sformatf("tbl%0d_int_n", i),  32'(bus.int_n),  32'(tbl[i].int_n));
         chk($sformatf("tbl%0d_dmao_n", i), 32'(bus.dmao_n), 32'(tbl[i].dmao_n));
         chk($sformatf("tbl%0d_disp", i),   32'(bus.display_enabled), 32'(tbl[i].de));
      end

      // Full frame with display off, random state codes
      step(1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0);
      efx_low = 0; int_low = 0; dma_low = 0; wr_cnt = 0;
      for (int i = 0; i < FRAME; i++) begin
         step(1'b1, 2'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b1);
         if (!bus.efx_n) efx_low++;
         if (!bus.int_n) int_low++;
         if (!bus.dmao_n) dma_low++;
         if (bus.fb_write_en) wr_cnt++;
      end
      chk("frame_efx_low_cycles", 32'(efx_low), 112);
      chk("frame_int_low_cycles", 32'(int_low), 0);
      chk("frame_dmao_low_cycles", 32'(dma_low), 0);
      chk("frame_write_count", 32'(wr_cnt), 0);

      // First DMA line: 8 bytes 0x01..0x08
      step(1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0);
      step(1'b0, 2'b00, 8'h00, 1'b1, 1'b0, 1'b1);
      adv_to(64, 2);
      for (int k = 0; k < 8; k++) begin
         step(1'b1, 2'b10, 8'(k + 1), 1'b0, 1'b0, 1'b1);
         chk("l64_wr_en", 32'(bus.fb_write_en), 1);
         chk("l64_addr", 32'(bus.fb_addr), 32'(k));
         chk("l64_data", 32'(bus.fb_data), 32'(k + 1));
      end
      chk("l64_dmao_after_8", 32'(bus.dmao_n), 1);

      // disp_off after 3rd byte on line 100
      adv_to(100, 2);
      for (int k = 0; k < 3; k++) begin
         step(1'b1, 2'b10, 8'(8'h30 + k), 1'b0, 1'b0, 1'b1);
         chk("l100_addr", 32'(bus.fb_addr), 32'(10'h120 + k));
      end
      step(1'b0, 2'b00, 8'h00, 1'b0, 1'b1, 1'b1);
      chk("l100_dmao_released", 32'(bus.dmao_n), 1);
      for (int k = 0; k < 3; k++) begin
         step(1'b1, 2'b10, 8'h55, 1'b0, 1'b0, 1'b1);
         chk("l100_no_write", 32'(bus.fb_write_en), 0);
      end
      chk("l100_addr_held", 32'(bus.fb_addr), 32'h122);

      // Last DMA line: 10 offered bytes, 8 accepted
      step(1'b0, 2'b00, 8'h00, 1'b1, 1'b0, 1'b1);
      adv_to(191, 2);
      wr_cnt = 0;
      for (int k = 0; k < 10; k++) begin
         step(1'b1, 2'b10, 8'hAA, 1'b0, 1'b0, 1'b1);
         if (bus.fb_write_en) wr_cnt++;
         if (k < 8) begin
            chk("l191_addr", 32'(bus.fb_addr), 32'(10'h3F8 + k));
            chk("l191_data", 32'(bus.fb_data), 32'hAA);
         end else begin
            chk("l191_extra_write", 32'(bus.fb_write_en), 0);
         end
      end
      chk("l191_write_count", 32'(wr_cnt), 8);
      adv_to(192, 2);
      chk("l192_dmao_n", 32'(bus.dmao_n), 1);

      // Reset on the clock of the 5th acceptance
      step(1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0);
      step(1'b0, 2'b00, 8'h00, 1'b1, 1'b0, 1'b1);
      adv_to(64, 2);
      for (int k = 0; k < 4; k++) step(1'b1, 2'b10, 8'(8'hC0 + k), 1'b0, 1'b0, 1'b1);
      chk("rst_pre_addr", 32'(bus.fb_addr), 3);
      step(1'b1, 2'b10, 8'hC4, 1'b0, 1'b0, 1'b0);
      chk("rst_wr_en", 32'(bus.fb_write_en), 0);
      chk("rst_addr", 32'(bus.fb_addr), 0);
      chk("rst_data", 32'(bus.fb_data), 0);
      chk("rst_dmao_n", 32'(bus.dmao_n), 1);
      chk("rst_int_n", 32'(bus.int_n), 1);
      chk("rst_efx_n", 32'(bus.efx_n), 1);
      chk("rst_display_enabled", 32'(bus.display_enabled), 0);
      idle();
      chk("rst_no_late_write", 32'(bus.fb_write_en), 0);

      // Randomised traffic against the model
      step(1'b0, 2'b00, 8'h00, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 9000; i++) begin
         step(($urandom % 4) != 0,
              ($urandom % 2) ? 2'b10 : 2'($urandom),
              8'($urandom),
              ($urandom % 150) == 0,
              ($urandom % 600) == 0,
              ($urandom % 4000) != 0);
      end
      idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
